// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: data-memory access, register writeback, PC redirect and halt.
// Define MEM_WAIT_TIMEOUT_EN to add a memory-wait watchdog with a sticky err_o.
module mem_wb_stage #(
  parameter int unsigned D_BITS       = 32,
  parameter int unsigned A_BITS       = 10,
  parameter int unsigned REG_BITS     = 3,
  parameter int unsigned JMP_OFF_BITS = 6
`ifdef MEM_WAIT_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT      = 15
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [D_BITS-1:0]   result_i,
  input  logic [A_BITS-1:0]   addr_i,
  input  logic [2:0]          flags_i,
  input  logic                store_i,
  input  logic                rel_i,
  input  logic [A_BITS-1:0]   pc_i,
  input  logic [REG_BITS-1:0] dst_i,
  output logic [A_BITS-1:0]   mem_addr_o,
  output logic [D_BITS-1:0]   mem_wdata_o,
  output logic                mem_rd_o,
  output logic                mem_wr_o,
  input  logic [D_BITS-1:0]   mem_rdata_i,
  input  logic                mem_ready_i,
  output logic                wb_en_o,
  output logic [REG_BITS-1:0] wb_sel_o,
  output logic [D_BITS-1:0]   wb_data_o,
  output logic                jmp_en_o,
  output logic [A_BITS-1:0]   jmp_pc_o,
  output logic                halt_o
`ifdef MEM_WAIT_TIMEOUT_EN
  ,
  output logic                err_o
`endif
);

  localparam int unsigned EXT_BITS = A_BITS - JMP_OFF_BITS;

  localparam logic [2:0] FLAG_WRITE = 3'd1;
  localparam logic [2:0] FLAG_READ  = 3'd2;
  localparam logic [2:0] FLAG_JUMP  = 3'd3;
  localparam logic [2:0] FLAG_STOP  = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    HALTED  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [A_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [D_BITS-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_rd_q, mem_rd_d;
  logic                mem_wr_q, mem_wr_d;
  logic [REG_BITS-1:0] rd_dst_q, rd_dst_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_BITS-1:0] wb_sel_q, wb_sel_d;
  logic [D_BITS-1:0]   wb_data_q, wb_data_d;
  logic                jmp_en_q, jmp_en_d;
  logic [A_BITS-1:0]   jmp_pc_q, jmp_pc_d;
  logic                halt_q, halt_d;

  logic [A_BITS-1:0]   jmp_off_c;
  logic [A_BITS-1:0]   jmp_tgt_c;
  logic                timeout_c;

  // Relative offsets are sign-extended; the add wraps modulo 2^A_BITS.
  assign jmp_off_c = {{EXT_BITS{result_i[JMP_OFF_BITS-1]}}, result_i[JMP_OFF_BITS-1:0]};
  assign jmp_tgt_c = rel_i ? (pc_i + jmp_off_c) : result_i[A_BITS-1:0];

`ifdef MEM_WAIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  assign timeout_c = !mem_ready_i && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

  // Counter is held at zero while idle, so each wait starts from zero.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    if (state_q == IDLE) begin
      wait_cnt_d = '0;
    end else if ((state_q == RD_WAIT) || (state_q == WR_WAIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (timeout_c) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    rd_dst_d    = rd_dst_q;
    wb_en_d     = 1'b0;
    wb_sel_d    = wb_sel_q;
    wb_data_d   = wb_data_q;
    jmp_en_d    = 1'b0;
    jmp_pc_d    = jmp_pc_q;
    halt_d      = halt_q;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          case (flags_i)
            FLAG_WRITE: begin
              if (store_i) begin
                state_d     = WR_WAIT;
                mem_wr_d    = 1'b1;
                mem_addr_d  = addr_i;
                mem_wdata_d = result_i;
              end else begin
                wb_en_d   = 1'b1;
                wb_sel_d  = dst_i;
                wb_data_d = result_i;
              end
            end
            FLAG_READ: begin
              state_d    = RD_WAIT;
              mem_rd_d   = 1'b1;
              mem_addr_d = addr_i;
              rd_dst_d   = dst_i;
            end
            FLAG_JUMP: begin
              jmp_en_d = 1'b1;
              jmp_pc_d = jmp_tgt_c;
            end
            FLAG_STOP: begin
              state_d = HALTED;
              halt_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        if (mem_ready_i) begin
          state_d   = IDLE;
          mem_rd_d  = 1'b0;
          wb_en_d   = 1'b1;
          wb_sel_d  = rd_dst_q;
          wb_data_d = mem_rdata_i;
        end else if (timeout_c) begin
          state_d  = HALTED;
          mem_rd_d = 1'b0;
          halt_d   = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ready_i) begin
          state_d  = IDLE;
          mem_wr_d = 1'b0;
        end else if (timeout_c) begin
          state_d  = HALTED;
          mem_wr_d = 1'b0;
          halt_d   = 1'b1;
        end
      end
      HALTED: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      rd_dst_q    <= '0;
      wb_en_q     <= 1'b0;
      wb_sel_q    <= '0;
      wb_data_q   <= '0;
      jmp_en_q    <= 1'b0;
      jmp_pc_q    <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      rd_dst_q    <= rd_dst_d;
      wb_en_q     <= wb_en_d;
      wb_sel_q    <= wb_sel_d;
      wb_data_q   <= wb_data_d;
      jmp_en_q    <= jmp_en_d;
      jmp_pc_q    <= jmp_pc_d;
      halt_q      <= halt_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign wb_en_o     = wb_en_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_data_o   = wb_data_q;
  assign jmp_en_o    = jmp_en_q;
  assign jmp_pc_o    = jmp_pc_q;
  assign halt_o      = halt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: random and directed operations against a queue-based reference.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] result_i;
  logic [9:0]  addr_i;
  logic [2:0]  flags_i;
  logic        store_i;
  logic        rel_i;
  logic [9:0]  pc_i;
  logic [2:0]  dst_i;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rd_o;
  logic        mem_wr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        wb_en_o;
  logic [2:0]  wb_sel_o;
  logic [31:0] wb_data_o;
  logic        jmp_en_o;
  logic [9:0]  jmp_pc_o;
  logic        halt_o;
`ifdef MEM_WAIT_TIMEOUT_EN
  logic        err_o;
`endif

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .result_i(result_i), .addr_i(addr_i), .flags_i(flags_i), .store_i(store_i),
    .rel_i(rel_i), .pc_i(pc_i), .dst_i(dst_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .wb_en_o(wb_en_o), .wb_sel_o(wb_sel_o), .wb_data_o(wb_data_o),
    .jmp_en_o(jmp_en_o), .jmp_pc_o(jmp_pc_o), .halt_o(halt_o)
`ifdef MEM_WAIT_TIMEOUT_EN
    , .err_o(err_o)
`endif
  );

  typedef struct { logic [2:0] sel; logic [31:0] data; } wb_t;
  typedef struct { logic wr; logic [9:0] addr; logic [31:0] data; } mop_t;

  wb_t         wb_q[$];
  logic [9:0]  jmp_q[$];
  mop_t        mem_q[$];
  logic [31:0] model_mem [1024];
  logic [31:0] resp_mem  [1024];

  int   errors = 0;
  int   checks = 0;
  int   force_lat = -1;
  int   lat = 0;
  bit   busy = 0, done_prev = 0, stall = 0, no_drop_chk = 0;
  logic exp_halt = 1'b0;
  logic [2:0]  last_sel = '0;
  logic [31:0] last_data = '0;
  logic [9:0]  last_pc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s at t=%0t", name, msg, $time);
  endtask

  // Drive one operation, wait for acceptance, and record what the stage must do with it.
  task automatic issue(input logic [2:0] f, input logic st, input logic rl, input logic [31:0] res,
                       input logic [9:0] ad, input logic [9:0] pc, input logic [2:0] ds);
    int   n;
    int   off;
    wb_t  w;
    mop_t m;
    n = 0;
    @(negedge clk);
    valid_i = 1'b1; flags_i = f; store_i = st; rel_i = rl;
    result_i = res; addr_i = ad; pc_i = pc; dst_i = ds;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      fail("accept_wait", "ready_o never returned high");
      valid_i = 1'b0;
      return;
    end
    case (f)
      3'd1: begin
        if (st) begin
          m.wr = 1'b1; m.addr = ad; m.data = res;
          mem_q.push_back(m);
          model_mem[ad] = res;
        end else begin
          w.sel = ds; w.data = res;
          wb_q.push_back(w);
        end
      end
      3'd2: begin
        m.wr = 1'b0; m.addr = ad; m.data = 32'd0;
        mem_q.push_back(m);
        w.sel = ds; w.data = model_mem[ad];
        wb_q.push_back(w);
      end
      3'd3: begin
        if (rl) begin
          off = int'(res[5:0]);
          if (off >= 32) off -= 64;
          jmp_q.push_back(10'((int'(pc) + off) & 1023));
        end else begin
          jmp_q.push_back(res[9:0]);
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (f == 3'd4) exp_halt = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'd0);
    chk({tag, "_mem_rdwr"}, 64'({mem_rd_o, mem_wr_o}), 64'd0);
    chk({tag, "_wb"}, 64'({wb_en_o, wb_sel_o, wb_data_o}), 64'd0);
    chk({tag, "_jmp"}, 64'({jmp_en_o, jmp_pc_o}), 64'd0);
    chk({tag, "_halt"}, 64'(halt_o), 64'd0);
    chk({tag, "_ready"}, 64'(ready_o), 64'd1);
`ifdef MEM_WAIT_TIMEOUT_EN
    chk({tag, "_err"}, 64'(err_o), 64'd0);
`endif
  endtask

  // Reset drops any pending expectation.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wb_q.delete(); jmp_q.delete(); mem_q.delete();
    exp_halt = 1'b0; stall = 0; no_drop_chk = 0; force_lat = -1;
    @(negedge clk);
    @(negedge clk);
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Memory responder: random latency, checks the request is held stable until completion.
  always @(negedge clk) begin
    mop_t m;
    mem_ready_i = 1'b0;
    mem_rdata_i = $urandom;
    if (rst) begin
      busy = 0;
      done_prev = 0;
    end else if (mem_rd_o || mem_wr_o) begin
      if (done_prev) fail("req_not_dropped", "request still high after ready");
      chk("req_exclusive", 64'(mem_rd_o & mem_wr_o), 64'd0);
      chk("ready_o_in_wait", 64'(ready_o), 64'd0);
      if (mem_q.size() == 0) begin
        fail("mem_unexpected", "memory request with nothing expected");
      end else begin
        m = mem_q[0];
        chk("mem_kind", 64'(mem_wr_o), 64'(m.wr));
        chk("mem_addr", 64'(mem_addr_o), 64'(m.addr));
        if (m.wr) chk("mem_wdata", 64'(mem_wdata_o), 64'(m.data));
      end
      if (!busy) begin
        busy = 1;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end
      done_prev = 0;
      if (!stall && lat == 0) begin
        mem_ready_i = 1'b1;
        if (mem_wr_o) resp_mem[mem_addr_o] = mem_wdata_o;
        else mem_rdata_i = resp_mem[mem_addr_o];
        if (mem_q.size() != 0) void'(mem_q.pop_front());
        busy = 0;
        done_prev = 1;
      end else if (lat > 0) begin
        lat--;
      end
    end else begin
      if (busy && !no_drop_chk) fail("req_dropped", "request dropped before ready");
      busy = 0;
      done_prev = 0;
      if ($urandom_range(0, 3) == 0) mem_ready_i = 1'b1;
    end
  end

  // Output monitor: pops expected writebacks and jumps, checks hold values and halt.
  always @(negedge clk) begin
    wb_t w;
    logic [9:0] p;
    if (rst) begin
      last_sel = '0; last_data = '0; last_pc = '0;
    end else begin
      if (wb_en_o) begin
        if (wb_q.size() == 0) begin
          fail("wb_unexpected", $sformatf("wb_sel=%0d wb_data=0x%0h", wb_sel_o, wb_data_o));
        end else begin
          w = wb_q.pop_front();
          chk("wb_sel", 64'(wb_sel_o), 64'(w.sel));
          chk("wb_data", 64'(wb_data_o), 64'(w.data));
          last_sel = w.sel;
          last_data = w.data;
        end
      end else begin
        chk("wb_hold", 64'({wb_sel_o, wb_data_o}), 64'({last_sel, last_data}));
      end
      if (jmp_en_o) begin
        if (jmp_q.size() == 0) begin
          fail("jmp_unexpected", $sformatf("jmp_pc=0x%0h", jmp_pc_o));
        end else begin
          p = jmp_q.pop_front();
          chk("jmp_pc", 64'(jmp_pc_o), 64'(p));
          last_pc = p;
        end
      end else begin
        chk("jmp_hold", 64'(jmp_pc_o), 64'(last_pc));
      end
      chk("halt", 64'(halt_o), 64'(exp_halt));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int r;
    rst = 1'b1; valid_i = 1'b0; flags_i = '0; store_i = 1'b0; rel_i = 1'b0;
    result_i = '0; addr_i = '0; pc_i = '0; dst_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = $urandom;
      resp_mem[i]  = model_mem[i];
    end
    model_mem[31] = 32'h1234;
    resp_mem[31]  = 32'h1234;
    do_reset("reset");

    // Back-to-back register writes.
    issue(3'd1, 1'b0, 1'b0, 32'hDEADBEEF, 10'h0, 10'h0, 3'd3);
    issue(3'd1, 1'b0, 1'b0, 32'd7, 10'h0, 10'h0, 3'd5);
    @(negedge clk);
    chk("b2b_ready", 64'(ready_o), 64'd1);

    // Read with three wait cycles.
    force_lat = 2;
    issue(3'd2, 1'b0, 1'b0, 32'h0, 10'h01F, 10'h0, 3'd6);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd_o) cnt++;
      else break;
    end
    chk("rd_cycles", 64'(cnt), 64'd3);
    chk("rd_wb_after", 64'(wb_en_o), 64'd1);

    // Store completing in the first wait cycle.
    force_lat = 0;
    issue(3'd1, 1'b1, 1'b0, 32'hA5, 10'h3FF, 10'h0, 3'd2);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_wr_o) cnt++;
      else break;
    end
    chk("wr_cycles", 64'(cnt), 64'd1);
    force_lat = -1;

    // Jumps, blank and unknown flags.
    issue(3'd3, 1'b0, 1'b1, 32'h0000_003C, 10'h0, 10'h002, 3'd0);
    issue(3'd3, 1'b0, 1'b0, 32'h0000_0155, 10'h0, 10'h0, 3'd0);
    issue(3'd0, 1'b1, 1'b1, 32'h1111, 10'h5, 10'h5, 3'd1);
    issue(3'd6, 1'b0, 1'b0, 32'h2222, 10'h5, 10'h5, 3'd1);

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      case (r)
        0, 1, 2: issue(3'd1, 1'b0, 1'($urandom), $urandom, 10'($urandom), 10'($urandom), 3'($urandom));
        3:       issue(3'd1, 1'b1, 1'($urandom), $urandom, 10'($urandom_range(0, 15)), 10'($urandom), 3'($urandom));
        4, 5:    issue(3'd2, 1'($urandom), 1'($urandom), $urandom, 10'($urandom_range(0, 15)), 10'($urandom), 3'($urandom));
        6:       issue(3'd3, 1'($urandom), 1'b0, $urandom, 10'($urandom), 10'($urandom), 3'($urandom));
        7:       issue(3'd3, 1'($urandom), 1'b1, $urandom, 10'($urandom), 10'($urandom), 3'($urandom));
        8:       issue(3'd0, 1'($urandom), 1'($urandom), $urandom, 10'($urandom), 10'($urandom), 3'($urandom));
        default: issue(3'($urandom_range(5, 7)), 1'($urandom), 1'($urandom), $urandom, 10'($urandom), 10'($urandom), 3'($urandom));
      endcase
    end
    for (int i = 0; i < 50; i++) begin
      if (wb_q.size() == 0 && jmp_q.size() == 0 && mem_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("drain_wb", 64'(wb_q.size()), 64'd0);
    chk("drain_jmp", 64'(jmp_q.size()), 64'd0);
    chk("drain_mem", 64'(mem_q.size()), 64'd0);

    // Reset while a read is outstanding.
    stall = 1;
    issue(3'd2, 1'b0, 1'b0, 32'h0, 10'h005, 10'h0, 3'd2);
    repeat (3) @(negedge clk);
    chk("rd_pending", 64'(mem_rd_o), 64'd1);
    do_reset("rst_mid_read");
    repeat (5) @(negedge clk);

    // STOP, then a write that must be ignored.
    issue(3'd4, 1'b0, 1'b0, 32'h0, 10'h0, 10'h0, 3'd0);
    @(negedge clk);
    chk("stop_halt", 64'(halt_o), 64'd1);
    valid_i = 1'b1; flags_i = 3'd1; store_i = 1'b0; result_i = 32'h99; dst_i = 3'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halted_ready", 64'(ready_o), 64'd0);
    end
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("rst_from_halt");

`ifdef MEM_WAIT_TIMEOUT_EN
    // Read that never completes trips the watchdog.
    stall = 1;
    no_drop_chk = 1;
    issue(3'd2, 1'b0, 1'b0, 32'h0, 10'h007, 10'h0, 3'd4);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("to_rd_held", 64'(mem_rd_o), 64'd1);
      chk("to_err_low", 64'(err_o), 64'd0);
    end
    @(posedge clk);
    #1;
    exp_halt = 1'b1;
    @(negedge clk);
    chk("to_rd_drop", 64'(mem_rd_o), 64'd0);
    chk("to_err", 64'(err_o), 64'd1);
    chk("to_halt", 64'(halt_o), 64'd1);
    do_reset("rst_after_timeout");
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the execute-stage result interface: takes result, address and flags from the ALU pipeline register and acts on them.
- Performs data-memory reads and writes over a ready-handshaked memory port, register-file writeback, PC redirect for jumps, and halt.
- Sits between execute and the register file / fetch; stalls execute via ready_o while a memory access is outstanding.

Parameters:
D_BITS, 32, data width of result, memory data and writeback data
A_BITS, 10, data-memory and PC address width
REG_BITS, 3, register index width
JMP_OFF_BITS, 6, width of the relative-jump offset carried in result_i[JMP_OFF_BITS-1:0]
TIMEOUT, 15, memory-wait limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
valid_i  in  1  execute presents an operation this cycle
ready_o  out  1  stage can accept; equals (state==IDLE), combinational from state
result_i  in  D_BITS  ALU result (writeback data, store data, or jump target/offset)
addr_i  in  A_BITS  memory address for READ/store
flags_i  in  3  0=BLANK, 1=WRITE, 2=READ, 3=JUMP, 4=STOP; other codes treated as BLANK
store_i  in  1  qualifies WRITE as memory store (opcode STORE) instead of register write
rel_i  in  1  qualifies JUMP as relative (JMPR/JMPRC)
pc_i  in  A_BITS  PC of the instruction, for relative jumps
dst_i  in  REG_BITS  destination register
mem_addr_o  out  A_BITS  memory address
mem_wdata_o  out  D_BITS  memory write data
mem_rd_o  out  1  memory read request
mem_wr_o  out  1  memory write request
mem_rdata_i  in  D_BITS  memory read data, valid with mem_ready_i
mem_ready_i  in  1  memory completes the current request
wb_en_o  out  1  register-file write strobe, one-cycle pulse
wb_sel_o  out  REG_BITS  register-file write index
wb_data_o  out  D_BITS  register-file write data
jmp_en_o  out  1  PC redirect strobe, one-cycle pulse
jmp_pc_o  out  A_BITS  redirect target
halt_o  out  1  processor halted, sticky

Behaviour:
- States: IDLE, RD_WAIT, WR_WAIT, HALTED. The transfer is accepted when valid_i && ready_o.
- Reset: state=IDLE. All outputs are 0: mem_*_o, wb_*_o, jmp_*_o and halt_o. Reset mid-access drops the request with no writeback and no memory retry.
- Register writeback (WRITE, !store_i): on the cycle after accept, wb_en_o=1, wb_sel_o=dst_i, wb_data_o=result_i. State stays IDLE, giving back-to-back throughput of 1 per cycle.
- Store (WRITE, store_i): move to WR_WAIT. From the next cycle, mem_wr_o=1, mem_addr_o=addr_i and mem_wdata_o=result_i, all held stable until mem_ready_i=1. On that cycle mem_wr_o drops the following cycle and state returns to IDLE. No writeback.
- READ: move to RD_WAIT, with mem_rd_o=1 and mem_addr_o=addr_i held until mem_ready_i=1. In the ready cycle mem_rdata_i and dst_i are captured. The next cycle gives wb_en_o=1 with the captured data, and state returns to IDLE.
- Minimum memory-op occupancy is 2 cycles (accept, then ready in the first wait cycle).
- JUMP: on the cycle after accept, jmp_en_o=1.
  - Absolute (!rel_i): jmp_pc_o=result_i[A_BITS-1:0].
  - Relative (rel_i): jmp_pc_o = pc_i + sign-extended result_i[JMP_OFF_BITS-1:0], truncated to A_BITS. Wrap-around modulo 2^A_BITS is required.
- STOP: move to HALTED and set halt_o=1 the next cycle. HALTED is left only by rst, and ready_o=0 in HALTED.
- BLANK or unknown flags: accept and do nothing.
- valid_i while ready_o=0: ignored. Execute must hold its inputs.
- wb_en_o and jmp_en_o are single-cycle pulses. wb_sel_o, wb_data_o and jmp_pc_o keep their last values when the strobe is low.
- mem_ready_i outside RD_WAIT/WR_WAIT is ignored.

Optional Feature:
- Macro: MEM_WAIT_TIMEOUT_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0) and a wait counter, cleared on entry to RD_WAIT or WR_WAIT and incremented each cycle in those states.
  - If the counter reaches TIMEOUT with mem_ready_i=0: deassert the request, skip writeback, set err_o=1 (sticky), and move to HALTED with halt_o=1.
- Undefined: no counter and no err_o port; the stage waits indefinitely.

Test Plan:
- WRITE dst=3 result=0xDEADBEEF, then WRITE dst=5 result=7 back-to-back -> wb_en_o pulses on 2 consecutive cycles, giving (3,0xDEADBEEF) then (5,7); ready_o stays 1.
- READ addr=0x01F, mem_ready_i after 3 wait cycles with rdata=0x1234 -> mem_rd_o high 3 cycles with addr 0x01F and ready_o=0; 1 cycle later wb_en_o=1, data 0x1234.
- Store addr=0x3FF data=0xA5 with mem_ready_i=1 immediately -> mem_wr_o high exactly 1 cycle, wb_en_o never asserted.
- JUMP rel pc_i=0x002 offset=6'b111100 (-4) -> jmp_pc_o=0x3FE (wrap), jmp_en_o 1 cycle; absolute result=0x155 -> jmp_pc_o=0x155.
- STOP, then valid_i WRITE -> halt_o=1, ready_o=0, no writeback. Reset during RD_WAIT -> all outputs 0 next cycle, no wb_en_o.
- With MEM_WAIT_TIMEOUT_EN, TIMEOUT=15, mem_ready_i held 0 -> after 15 wait cycles mem_rd_o=0, err_o=1, halt_o=1.
